ext_int_source: RTL and testbench

//  Producer side of the n_clic pend/clear handshake for external pins. Synchronises Lines async inputs and edge/level-detects them per line.

---
 rtl/ext_int_source_pkg.sv | 46 ++++
 rtl/ext_int_source_line.sv | 85 ++++++++
 rtl/ext_int_source.sv | 63 ++++++
 tb/tb_ext_int_source.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_int_source_pkg.sv
// rtl/ext_int_source_pkg.sv - shared types and constants for the external interrupt source
package ext_int_source_pkg;

   localparam int          ExtIntLines   = 4;
   localparam int          ExtCntWidth   = 4;
   localparam logic [11:0] ExtIntCsrBase = 12'h7C0;
   localparam int          WordW         = 32;

   typedef logic [11:0]      CsrAddrT;
   typedef logic [WordW-1:0] word_t;

   typedef enum logic [1:0] {
      EXT_RISE  = 2'd0,
      EXT_FALL  = 2'd1,
      EXT_BOTH  = 2'd2,
      EXT_LEVEL = 2'd3
   } ExtModeT;

   // Encoding follows the csr funct3 field; bit 2 selects the immediate operand.
   typedef enum logic [2:0] {
      CSR_NONE = 3'd0,
      CSR_RW   = 3'd1,
      CSR_RS   = 3'd2,
      CSR_RC   = 3'd3,
      CSR_RWI  = 3'd5,
      CSR_RSI  = 3'd6,
      CSR_RCI  = 3'd7
   } csr_op_t;

   typedef struct packed {
      logic [ExtCntWidth-1:0] count;
      logic                   ovf;
      logic                   enable;
      ExtModeT                mode;
   } ext_cfg_t;

   function automatic word_t csr_apply(csr_op_t op, word_t old, word_t src);
      case (op)
         CSR_RW, CSR_RWI: return src;
         CSR_RS, CSR_RSI: return old | src;
         CSR_RC, CSR_RCI: return old & ~src;
         default:         return old;
      endcase
   endfunction

endpackage

// File: rtl/ext_int_source_line.sv
// rtl/ext_int_source_line.sv - one external line: synchroniser, edge detect, event counter, csr
module ext_int_line
   import ext_int_source_pkg::*;
#(
   parameter int CntWidth = ExtCntWidth
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ext_in,
   input  logic                interrupt_clear,
   input  logic                wr_en,
   input  logic [CntWidth+3:0] wr_data,
   output logic                interrupt_set,
   output logic [CntWidth+3:0] rd_data
);

   typedef struct packed {
      logic [CntWidth-1:0] count;
      logic                ovf;
      logic                enable;
      ExtModeT             mode;
   } line_cfg_t;

   localparam logic [CntWidth-1:0] CntMax = '1;

   logic      s1, s2, prev;
   logic      edge_hit, evt, clr;
   line_cfg_t cfg, cfg_nxt;

   // Two-flop synchroniser plus one history flop for edge detection.
   always_ff @(posedge clk) begin
      if (!reset) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         prev <= 1'b0;
      end else begin
         s1   <= ext_in;
         s2   <= s1;
         prev <= s2;
      end
   end

   // Select which synchronised transition counts as an event; level mode never counts.
   always_comb begin
      edge_hit = 1'b0;
      case (cfg.mode)
         EXT_RISE:  edge_hit = s2 & ~prev;
         EXT_FALL:  edge_hit = ~s2 & prev;
         EXT_BOTH:  edge_hit = s2 ^ prev;
         default:   edge_hit = 1'b0;
      endcase
   end

   assign evt = cfg.enable & edge_hit;
   assign clr = interrupt_clear & (cfg.mode != EXT_LEVEL) & (cfg.count != '0);

   // Next register value: software write wins, then event/clear bookkeeping.
   always_comb begin
      cfg_nxt = cfg;
      if (wr_en) begin
         cfg_nxt = line_cfg_t'(wr_data);
      end else if (evt && !clr) begin
         if (cfg.count == CntMax) begin
            cfg_nxt.ovf = 1'b1;
         end else begin
            cfg_nxt.count = cfg.count + 1'b1;
         end
      end else if (clr && !evt) begin
         cfg_nxt.count = cfg.count - 1'b1;
      end
   end

   // Line configuration/status register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cfg <= '0;
      end else begin
         cfg <= cfg_nxt;
      end
   end

   assign interrupt_set = cfg.enable & ((cfg.mode == EXT_LEVEL) ? s2 : (cfg.count != '0));
   assign rd_data       = cfg;

endmodule

// File: rtl/ext_int_source.sv
// rtl/ext_int_source.sv - external interrupt source lines feeding the n_clic pend/clear handshake
module ext_int_source
   import ext_int_source_pkg::*;
#(
   parameter int      Lines    = ExtIntLines,
   parameter int      CntWidth = ExtCntWidth,
   parameter CsrAddrT Addr     = ExtIntCsrBase
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             csr_enable,
   input  CsrAddrT          csr_addr,
   input  csr_op_t          csr_op,
   input  logic [4:0]       rs1_zimm,
   input  word_t            rs1_data,
   input  logic [Lines-1:0] ext_in,
   input  logic [Lines-1:0] interrupt_clear,
   output logic [Lines-1:0] interrupt_set,
   output word_t            csr_out
);

   localparam int RegW = 4 + CntWidth;

   logic [RegW-1:0]  rd_data [Lines];
   logic [Lines-1:0] hit;
   logic             csr_write;
   logic             imm_op;
   word_t            operand, old_val, new_val;
   logic             unused_hi;

   assign imm_op    = (csr_op == CSR_RWI) || (csr_op == CSR_RSI) || (csr_op == CSR_RCI);
   assign operand   = imm_op ? word_t'(rs1_zimm) : rs1_data;
   assign csr_write = csr_enable && (csr_op != CSR_NONE);

   // Read mux: at most one line decodes, anything else reads as zero.
   always_comb begin
      old_val = '0;
      for (int i = 0; i < Lines; i++) begin
         if (hit[i]) old_val = word_t'(rd_data[i]);
      end
   end

   // One shared op evaluator; only the addressed line takes the result.
   assign new_val   = csr_apply(csr_op, old_val, operand);
   assign csr_out   = old_val;
   assign unused_hi = ^new_val[WordW-1:RegW];

   for (genvar k = 0; k < Lines; k++) begin : g_line
      assign hit[k] = (csr_addr == CsrAddrT'(Addr + k));

      ext_int_line #(.CntWidth(CntWidth)) u_line (
         .clk             (clk),
         .reset           (reset),
         .ext_in          (ext_in[k]),
         .interrupt_clear (interrupt_clear[k]),
         .wr_en           (csr_write & hit[k]),
         .wr_data         (new_val[RegW-1:0]),
         .interrupt_set   (interrupt_set[k]),
         .rd_data         (rd_data[k])
      );
   end

endmodule

// File: tb/tb_ext_int_source.sv
// tb/tb_ext_int_source.sv - self-checking bench for ext_int_source
module tb_ext_int_source;
   import ext_int_source_pkg::*;

   localparam int L    = ExtIntLines;
   localparam int CW   = ExtCntWidth;
   localparam int CMAX = (1 << CW) - 1;

   logic         clk = 1'b0;
   logic         reset;
   logic         csr_enable;
   CsrAddrT      csr_addr;
   csr_op_t      csr_op;
   logic [4:0]   rs1_zimm;
   word_t        rs1_data;
   logic [L-1:0] ext_in;
   logic [L-1:0] interrupt_clear;
   logic [L-1:0] interrupt_set;
   word_t        csr_out;

   always #5 clk = ~clk;

   ext_int_source dut (
      .clk             (clk),
      .reset           (reset),
      .csr_enable      (csr_enable),
      .csr_addr        (csr_addr),
      .csr_op          (csr_op),
      .rs1_zimm        (rs1_zimm),
      .rs1_data        (rs1_data),
      .ext_in          (ext_in),
      .interrupt_clear (interrupt_clear),
      .interrupt_set   (interrupt_set),
      .csr_out         (csr_out)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: per-line fields as integers plus a history of pin samples.
   int           m_mode [L];
   int           m_en   [L];
   int           m_ovf  [L];
   int           m_cnt  [L];
   logic [L-1:0] samp[$];

   function automatic word_t m_reg(int k);
      return word_t'((m_cnt[k] << 4) | (m_ovf[k] << 3) | (m_en[k] << 2) | m_mode[k]);
   endfunction

   function automatic int line_of(CsrAddrT a);
      int d;
      d = int'(a) - int'(ExtIntCsrBase);
      return (d >= 0 && d < L) ? d : -1;
   endfunction

   task automatic chk(string tag, word_t obs, word_t exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Pin seen by the line logic is the sample from two edges ago; prior one is three ago.
   task automatic model_edge();
      word_t src, old, nv;
      logic  lvl, pv, ev, cl;
      if (!reset) begin
         for (int k = 0; k < L; k++) begin
            m_mode[k] = 0; m_en[k] = 0; m_ovf[k] = 0; m_cnt[k] = 0;
         end
         samp.delete();
         repeat (3) samp.push_back('0);
         return;
      end
      src = (csr_op == CSR_RWI || csr_op == CSR_RSI || csr_op == CSR_RCI) ? word_t'(rs1_zimm) : rs1_data;
      for (int k = 0; k < L; k++) begin
         lvl = samp[samp.size()-2][k];
         pv  = samp[samp.size()-3][k];
         if (csr_enable && csr_op != CSR_NONE && line_of(csr_addr) == k) begin
            old = m_reg(k);
            case (csr_op)
               CSR_RW, CSR_RWI: nv = src;
               CSR_RS, CSR_RSI: nv = old | src;
               default:         nv = old & ~src;
            endcase
            m_mode[k] = int'(nv[1:0]);
            m_en[k]   = int'(nv[2]);
            m_ovf[k]  = int'(nv[3]);
            m_cnt[k]  = int'(nv[CW+3:4]);
         end else if (m_mode[k] != 3) begin
            if (m_mode[k] == 0)      ev = lvl && !pv;
            else if (m_mode[k] == 1) ev = !lvl && pv;
            else                     ev = (lvl != pv);
            ev = ev && (m_en[k] != 0);
            cl = interrupt_clear[k] && (m_cnt[k] > 0);
            if (ev && !cl) begin
               if (m_cnt[k] == CMAX) m_ovf[k] = 1;
               else                  m_cnt[k] = m_cnt[k] + 1;
            end else if (cl && !ev) begin
               m_cnt[k] = m_cnt[k] - 1;
            end
         end
      end
      samp.push_back(ext_in);
      if (samp.size() > 4) void'(samp.pop_front());
   endtask

   task automatic check_outputs();
      logic [L-1:0] es;
      word_t        eo;
      int           ln;
      for (int k = 0; k < L; k++) begin
         if (m_mode[k] == 3) es[k] = (m_en[k] != 0) && samp[samp.size()-2][k];
         else                es[k] = (m_en[k] != 0) && (m_cnt[k] != 0);
      end
      ln = line_of(csr_addr);
      eo = (ln >= 0) ? m_reg(ln) : '0;
      chk("model_set", word_t'(interrupt_set), word_t'(es));
      chk("model_csr_out", csr_out, eo);
   endtask

   task automatic tick();
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic csr_access(csr_op_t op, int line, logic [4:0] zimm, word_t data);
      csr_enable = 1'b1;
      csr_op     = op;
      csr_addr   = CsrAddrT'(int'(ExtIntCsrBase) + line);
      rs1_zimm   = zimm;
      rs1_data   = data;
      tick();
      csr_enable = 1'b0;
      csr_op     = CSR_NONE;
   endtask

   task automatic lit(string tag, int line, word_t exp);
      csr_addr = CsrAddrT'(int'(ExtIntCsrBase) + line);
      #1;
      chk(tag, csr_out, exp);
   endtask

   task automatic lit_bit(string tag, int k, logic exp);
      chk(tag, word_t'(interrupt_set[k]), word_t'(exp));
   endtask

   int opv [7] = '{0, 1, 2, 3, 5, 6, 7};

   initial begin
      reset = 1'b0; csr_enable = 1'b0; csr_op = CSR_NONE; csr_addr = ExtIntCsrBase;
      rs1_zimm = '0; rs1_data = '0; ext_in = '0; interrupt_clear = '0;
      @(posedge clk);
      model_edge();
      #1;

      // reset held with pins toggling
      ext_in = '1; tick();
      ext_in = '0; interrupt_clear = '1; tick();
      interrupt_clear = '0;
      chk("reset_set", word_t'(interrupt_set), '0);
      lit("reset_csr", 0, '0);
      reset = 1'b1;
      repeat (3) tick();
      lit("reset_cnt", 0, '0);

      // rising edge latency on line 0
      csr_access(CSR_RWI, 0, 5'h4, '0);
      ext_in[0] = 1'b1;
      tick(); lit_bit("rise_e0", 0, 1'b0);
      tick(); lit_bit("rise_e1", 0, 1'b0);
      tick(); lit_bit("rise_e2", 0, 1'b1);
      lit("rise_cnt", 0, 32'h14);
      interrupt_clear[0] = 1'b1; tick(); interrupt_clear[0] = 1'b0;
      lit_bit("rise_clr", 0, 1'b0);
      lit("rise_clr_cnt", 0, 32'h04);

      // both-edge burst then drain
      csr_access(CSR_RWI, 0, 5'h6, '0);
      repeat (3) tick();
      ext_in[0] = 1'b0; repeat (2) tick();
      ext_in[0] = 1'b1; repeat (2) tick();
      ext_in[0] = 1'b0; repeat (4) tick();
      lit("burst_cnt", 0, 32'h36);
      for (int i = 0; i < 3; i++) begin
         interrupt_clear[0] = 1'b1; tick();
         interrupt_clear[0] = 1'b0; tick();
         lit("burst_drain", 0, word_t'(((2 - i) << 4) | 6));
         lit_bit("burst_set", 0, (i != 2));
      end

      // collision at saturation, then overflow, then sw clears ovf
      csr_access(CSR_RW, 0, '0, 32'hF6);
      ext_in[0] = 1'b1; tick(); tick();
      interrupt_clear[0] = 1'b1; tick(); interrupt_clear[0] = 1'b0;
      lit("collide", 0, 32'hF6);
      ext_in[0] = 1'b0; repeat (3) tick();
      lit("sat_ovf", 0, 32'hFE);
      csr_access(CSR_RCI, 0, 5'h8, '0);
      lit("ovf_clr", 0, 32'hF6);

      // level mode on line 1
      csr_access(CSR_RWI, 1, 5'h7, '0);
      ext_in[1] = 1'b1;
      tick(); lit_bit("lvl_e1", 1, 1'b0);
      tick(); lit_bit("lvl_e2", 1, 1'b1);
      interrupt_clear[1] = 1'b1; tick(); interrupt_clear[1] = 1'b0;
      lit_bit("lvl_clr", 1, 1'b1);
      lit("lvl_cnt", 1, 32'h07);
      ext_in[1] = 1'b0;
      tick(); lit_bit("lvl_low1", 1, 1'b1);
      tick(); lit_bit("lvl_low2", 1, 1'b0);

      // csr write beats a same-cycle event
      csr_access(CSR_RWI, 2, 5'h4, '0);
      ext_in[2] = 1'b1; tick(); tick();
      csr_access(CSR_RC, 2, '0, 32'hF0);
      lit("prio_cnt", 2, 32'h04);
      lit_bit("prio_set", 2, 1'b0);

      // address just past the last line reads zero
      csr_enable = 1'b1;
      lit("oob_read", L, '0);
      csr_enable = 1'b0;

      // disabled lines drop events and keep their count
      ext_in[3] = 1'b1; repeat (3) tick();
      lit("dis_drop", 3, '0);
      csr_access(CSR_RCI, 0, 5'h4, '0);
      lit("dis_keep", 0, 32'hF2);
      ext_in[0] = 1'b1; repeat (3) tick();
      lit("dis_drop0", 0, 32'hF2);
      lit_bit("dis_set", 0, 1'b0);

      // randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         ext_in          = L'($urandom);
         interrupt_clear = L'($urandom & $urandom);
         if ($urandom_range(0, 3) == 0) begin
            csr_enable = 1'b1;
            csr_op     = csr_op_t'(3'(opv[$urandom_range(0, 6)]));
            csr_addr   = CsrAddrT'(int'(ExtIntCsrBase) + int'($urandom_range(0, L)));
            rs1_zimm   = 5'($urandom);
            rs1_data   = $urandom;
         end else begin
            csr_enable = 1'b0;
            csr_op     = CSR_NONE;
            csr_addr   = CsrAddrT'(int'(ExtIntCsrBase) + int'($urandom_range(0, L)));
         end
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
